lc3_regfile: RTL and testbench

// - LC-3 general-purpose register file: 8 registers x 16 bits (R0-R7).
// - Single shared select: sel picks the register that is both written and read.
// - Synchronous write, combinational (asynchronous) read.
// - Sits in the LC-3 datapath, fed from the bus and read by the ALU/address logic.

---
 rtl/lc3_regfile.sv | 33 +++
 tb/tb_lc3_regfile.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - LC-3 general-purpose register file, shared read/write select
module lc3_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] regs [DEPTH];

  // Reset clears every register and wins over a same-edge write; otherwise write the selected one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[sel] <= in;
    end
  end

  // Read port is purely combinational with no write bypass.
  always_comb begin
    out = regs[sel];
  end

endmodule

// File: tb/tb_lc3_regfile.sv
// tb/tb_lc3_regfile.sv - directed scoreboard bench for lc3_regfile
module tb_lc3_regfile;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [15:0] in;
  logic [2:0]  sel;
  logic [15:0] out;

  logic [15:0] mdl [8];
  logic [15:0] exp_q [$];
  int          vectors;
  int          miscompares;

  lc3_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .in       (in),
    .sel      (sel),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, mirror its effect in the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    end else if (write_en) begin
      mdl[sel] = in;
    end
    #1;
  endtask

  // Queue the value the model says out should show for the current sel.
  task automatic push_expect();
    exp_q.push_back(mdl[sel]);
  endtask

  // Pop the oldest expectation and compare against the DUT output.
  task automatic check(input string tag);
    logic [15:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, out);
    end else begin
      e = exp_q.pop_front();
      assert (out === e) else begin
        miscompares++;
        $error("FAIL %s: sel=%0d observed %h expected %h", tag, sel, out, e);
      end
    end
  endtask

  task automatic read_at(input int idx, input string tag);
    sel = idx[2:0];
    #1;
    push_expect();
    check(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'hxxxx;
    reset    = 1'b1;
    write_en = 1'b0;
    in       = 16'h0000;
    sel      = 3'd0;

    // reset for one edge, then every register reads zero
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) read_at(i, "reset_sweep");

    // R0 write of all ones, visible right after the first edge
    sel = 3'd0; in = 16'hFFFF; write_en = 1'b1;
    tick();
    exp_q.push_back(16'hFFFF);
    check("r0_write");
    tick();
    write_en = 1'b0; in = 16'h0000;
    tick();
    exp_q.push_back(16'hFFFF);
    check("r0_hold_we0");

    // isolation between R1 and R0
    read_at(1, "r1_before");
    write_en = 1'b1; in = 16'h0001;
    tick();
    exp_q.push_back(16'h0001);
    check("r1_write");
    write_en = 1'b0;
    read_at(0, "r0_untouched");

    // no bypass: old value before the edge, new value after
    sel = 3'd2; in = 16'h1234; write_en = 1'b1;
    #1;
    exp_q.push_back(16'h0000);
    check("no_bypass_pre");
    tick();
    exp_q.push_back(16'h1234);
    check("no_bypass_post");

    // held write_en rewrites with the current in on every edge
    sel = 3'd5; in = 16'h0A0A;
    tick();
    in = 16'hB0B0;
    tick();
    exp_q.push_back(16'hB0B0);
    check("held_write");
    write_en = 1'b0; in = 16'hDEAD;
    tick();
    exp_q.push_back(16'hB0B0);
    check("in_ignored");

    // reset wins over a same-edge write
    sel = 3'd3; in = 16'hABCD; write_en = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; write_en = 1'b0;
    for (int i = 0; i < 8; i++) read_at(i, "reset_priority");

    // walk all registers with distinct patterns, then read back
    write_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      in  = 16'(16'h1111 * i);
      tick();
    end
    write_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      #1;
      exp_q.push_back(16'(16'h1111 * i));
      check("walk_all");
    end

    // idempotent rewrite of the same value
    sel = 3'd7; in = 16'h7777; write_en = 1'b1;
    tick();
    tick();
    write_en = 1'b0;
    read_at(7, "idempotent");
    read_at(6, "idempotent_neighbor");

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
